// File: rtl/coin_key_input_pkg.sv
// Shared definitions for the coin-input front end: filter state encoding and counter sizing.
package coin_key_input_pkg;

  localparam int unsigned CNT_W = 20;
  // 20 ms at 50 MHz, minus one
  localparam logic [CNT_W-1:0] CNT_MAX_DEFAULT = 20'd999_999;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StFiltDn = 2'd1,
    StDown   = 2'd2,
    StFiltUp = 2'd3
  } key_state_e;

endpackage

// File: rtl/coin_key_input_key_filter.sv
// Synchronises one active-low button and debounces both edges; emits a 1-cycle press pulse.
module key_filter
  import coin_key_input_pkg::*;
#(
  parameter logic [CNT_W-1:0] CNT_MAX = CNT_MAX_DEFAULT
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key_n_i,
  output logic press_o
);

  logic [1:0]       sync_q;
  logic             key_s;
  key_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign key_s = sync_q[1];

  // Presets to released so a key held through reset is debounced as a fresh press.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync_q  <= 2'b11;
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      sync_q  <= {sync_q[0], key_n_i};
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    press_o = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!key_s) begin
          state_d = StFiltDn;
          cnt_d   = '0;
        end
      end
      StFiltDn: begin
        if (key_s) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = StDown;
          cnt_d   = '0;
          press_o = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StDown: begin
        if (key_s) begin
          state_d = StFiltUp;
          cnt_d   = '0;
        end
      end
      StFiltUp: begin
        if (!key_s) begin
          state_d = StDown;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: rtl/coin_key_input.sv
// Two debounced coin buttons merged into mutually exclusive registered pulses.
module coin_key_input
  import coin_key_input_pkg::*;
#(
  parameter logic [CNT_W-1:0] CNT_MAX = CNT_MAX_DEFAULT
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key_half,
  input  logic key_one,
  output logic po_money_half,
  output logic po_money_one
);

  logic press_half, press_one;
  logic half_q, half_d;
  logic one_q, one_d;
  logic pend_q, pend_d;

  key_filter #(.CNT_MAX(CNT_MAX)) u_filter_half (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .key_n_i   (key_half),
    .press_o   (press_half)
  );

  key_filter #(.CNT_MAX(CNT_MAX)) u_filter_one (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .key_n_i   (key_one),
    .press_o   (press_one)
  );

  // Half coin has priority; a colliding 1-yuan coin waits in the pending slot.
  always_comb begin
    half_d = 1'b0;
    one_d  = 1'b0;
    pend_d = pend_q;
    if (press_half) begin
      half_d = 1'b1;
      if (press_one) pend_d = 1'b1;
    end else if (press_one || pend_q) begin
      one_d  = 1'b1;
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      half_q <= 1'b0;
      one_q  <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      half_q <= half_d;
      one_q  <= one_d;
      pend_q <= pend_d;
    end
  end

  assign po_money_half = half_q;
  assign po_money_one  = one_q;

endmodule

// File: tb/tb_coin_key_input.sv
// Bench for coin_key_input: run-length debounce model plus directed latency/arbitration checks.
module tb_coin_key_input;

  localparam int CM  = 9;
  localparam int RUN = CM + 2;  // consecutive samples needed to accept a level change

  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  logic key_half = 1'b1;
  logic key_one = 1'b1;
  logic po_money_half, po_money_one;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int half_cnt = 0, one_cnt = 0;
  int last_half_edge = -1, last_one_edge = -1;

  coin_key_input #(.CNT_MAX(20'd9)) dut (
    .sys_clk       (sys_clk),
    .sys_rst_n     (sys_rst_n),
    .key_half      (key_half),
    .key_one       (key_one),
    .po_money_half (po_money_half),
    .po_money_one  (po_money_one)
  );

  always #10 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  // Reference: a key press is accepted when an armed key has been sampled low for RUN
  // consecutive edges; it re-arms after RUN consecutive high samples. Accepted presses
  // reach the outputs two edges later; half coins win, 1-yuan coins owed are paid later.
  int  low_run [2];
  int  high_run[2];
  bit  armed   [2];
  bit  ph1, po1, ph2, po2;
  int  owed;
  bit  exp_half, exp_one;

  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int k = 0; k < 2; k++) begin
        low_run[k]  <= 0;
        high_run[k] <= 0;
        armed[k]    <= 1'b1;
      end
      ph1 <= 1'b0; po1 <= 1'b0; ph2 <= 1'b0; po2 <= 1'b0;
      owed <= 0;
      exp_half <= 1'b0;
      exp_one  <= 1'b0;
    end else begin
      bit lvl [2];
      bit det [2];
      lvl[0] = key_half;
      lvl[1] = key_one;
      for (int k = 0; k < 2; k++) begin
        det[k] = 1'b0;
        if (lvl[k]) begin
          low_run[k]  <= 0;
          high_run[k] <= high_run[k] + 1;
          if (!armed[k] && high_run[k] + 1 == RUN) armed[k] <= 1'b1;
        end else begin
          high_run[k] <= 0;
          low_run[k]  <= low_run[k] + 1;
          if (armed[k] && low_run[k] + 1 == RUN) begin
            det[k]   = 1'b1;
            armed[k] <= 1'b0;
          end
        end
      end
      if (ph2) begin
        exp_half <= 1'b1;
        exp_one  <= 1'b0;
        owed     <= owed + int'(po2);
      end else if (po2 || owed > 0) begin
        exp_half <= 1'b0;
        exp_one  <= 1'b1;
        owed     <= owed + int'(po2) - 1;
      end else begin
        exp_half <= 1'b0;
        exp_one  <= 1'b0;
      end
      ph2 <= ph1;
      po2 <= po1;
      ph1 <= det[0];
      po1 <= det[1];
    end
  end

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
    end
  endtask

  // Per-cycle compare against the model, plus pulse bookkeeping for directed checks.
  initial begin
    forever begin
      @(negedge sys_clk);
      check("po_money_half", int'(po_money_half), int'(exp_half));
      check("po_money_one", int'(po_money_one), int'(exp_one));
      check("exclusive", int'(po_money_half && po_money_one), 0);
      if (po_money_half) begin
        half_cnt++;
        last_half_edge = cyc;
      end
      if (po_money_one) begin
        one_cnt++;
        last_one_edge = cyc;
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic drive_one(input bit lvl, input int n);
    key_one = lvl;
    wait_cyc(n);
  endtask

  initial begin
    int t0, h0, o0;
    int rem_h, rem_o;

    #5;
    check("reset_half", int'(po_money_half), 0);
    check("reset_one", int'(po_money_one), 0);
    #15 sys_rst_n = 1'b1;
    wait_cyc(5);

    // 1: clean half press
    h0 = half_cnt; o0 = one_cnt;
    key_half = 1'b0; t0 = cyc + 1;
    wait_cyc(30);
    key_half = 1'b1;
    wait_cyc(30);
    check("t1_half_count", half_cnt - h0, 1);
    check("t1_latency", last_half_edge - t0, 12);
    check("t1_one_count", one_cnt - o0, 0);

    // 2: bouncy 1-yuan press and release
    h0 = half_cnt; o0 = one_cnt;
    for (int i = 0; i < 5; i++) drive_one(i[0], 3);
    drive_one(1'b0, 20);
    for (int i = 0; i < 5; i++) drive_one(~i[0], 3);
    drive_one(1'b1, 30);
    check("t2_one_count", one_cnt - o0, 1);
    check("t2_half_count", half_cnt - h0, 0);

    // 3: simultaneous press
    h0 = half_cnt; o0 = one_cnt;
    key_half = 1'b0; key_one = 1'b0; t0 = cyc + 1;
    wait_cyc(30);
    key_half = 1'b1; key_one = 1'b1;
    wait_cyc(30);
    check("t3_half_edge", last_half_edge - t0, 12);
    check("t3_one_edge", last_one_edge - t0, 13);
    check("t3_counts", (half_cnt - h0) * 10 + (one_cnt - o0), 11);

    // 4: long hold, release, re-press
    h0 = half_cnt;
    key_half = 1'b0;
    wait_cyc(200);
    key_half = 1'b1;
    wait_cyc(30);
    key_half = 1'b0; t0 = cyc + 1;
    wait_cyc(30);
    key_half = 1'b1;
    wait_cyc(30);
    check("t4_half_count", half_cnt - h0, 2);
    check("t4_latency", last_half_edge - t0, 12);

    // 5: short glitches, separate and together
    h0 = half_cnt; o0 = one_cnt;
    key_half = 1'b0; wait_cyc(8); key_half = 1'b1; wait_cyc(20);
    key_one = 1'b0; wait_cyc(8); key_one = 1'b1; wait_cyc(20);
    key_half = 1'b0; key_one = 1'b0; wait_cyc(8);
    key_half = 1'b1; key_one = 1'b1; wait_cyc(20);
    check("t5_glitch", (half_cnt - h0) + (one_cnt - o0), 0);

    // 6: reset mid-filter, key still held after release
    h0 = half_cnt;
    key_half = 1'b0;
    wait_cyc(6);
    #5 sys_rst_n = 1'b0;
    #1;
    check("t6_rst_half", int'(po_money_half), 0);
    check("t6_rst_one", int'(po_money_one), 0);
    #19 sys_rst_n = 1'b1;
    t0 = cyc + 1;
    wait_cyc(25);
    key_half = 1'b1;
    wait_cyc(30);
    check("t6_half_count", half_cnt - h0, 1);
    check("t6_latency", last_half_edge - t0, 12);

    // Random runs on both keys, checked by the model every cycle
    rem_h = 0; rem_o = 0;
    for (int i = 0; i < 4000; i++) begin
      if (rem_h == 0) begin
        key_half = 1'($urandom_range(0, 1));
        rem_h = $urandom_range(1, 25);
      end
      if (rem_o == 0) begin
        key_one = 1'($urandom_range(0, 1));
        rem_o = $urandom_range(1, 25);
      end
      if ($urandom_range(0, 15) == 0) begin
        key_one = key_half;
        rem_o = rem_h;
      end
      rem_h--; rem_o--;
      @(negedge sys_clk);
    end
    key_half = 1'b1; key_one = 1'b1;
    wait_cyc(40);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
